// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the CPU-to-unified-memory bridge.
// Holds the sequencer state encoding and the bus alignment helper.
package mem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } bridge_state_t;

    localparam logic [3:0]  BYTEEN_ALL      = 4'hF;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_bus_bridge_watchdog.sv
// bus_watchdog: counts consecutive stalled request cycles and raises a
// sticky error once the limit is hit; expire_o aborts the transfer.
module bus_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    output logic expire_o,
    output logic error_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign expire_o = stall_i && (cnt_q == CW'(LIMIT - 1));
    assign error_o  = err_q;

    // Count while stalled, clear on completion, abort or idle.
    always_comb begin
        cnt_d = '0;
        err_d = err_q | expire_o;
        if (stall_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: serialises fetch and data access onto one bus and
// strobes clk_enable per instruction. Option: MEM_BUS_BRIDGE_TIMEOUT_EN.
import mem_bus_bridge_pkg::*;

module mem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        bus_error
);

    bridge_state_t state_q, state_d;
    logic          wr_q;
    logic [31:0]   instr_q;
    logic [31:0]   data_q;
    logic          expire;
    logic          done;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    logic stall;

    assign stall = ((state_q == FETCH) || (state_q == DATA)) && waitrequest;

    bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .stall_i  (stall),
        .expire_o (expire),
        .error_o  (bus_error)
    );
`else
    assign expire    = 1'b0;
    assign bus_error = 1'b0;
`endif

    // A transfer ends on a non-stalled edge or on a watchdog abort.
    assign done = !waitrequest || expire;

    assign instr_readdata = instr_q;
    assign data_readdata  = data_q;
    assign byteenable     = BYTEEN_ALL;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  if (done) state_d = DECODE;
            DECODE: state_d = (data_read || data_write) ? DATA : COMMIT;
            DATA:   if (done) state_d = COMMIT;
            COMMIT: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Bus and strobe outputs; reset drops the request asynchronously.
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        clk_enable = 1'b0;
        if (!reset) begin
            unique case (state_q)
                FETCH: begin
                    read    = 1'b1;
                    address = align_word(instr_address);
                end
                DATA: begin
                    address = align_word(data_address);
                    if (wr_q) begin
                        write     = 1'b1;
                        writedata = data_writedata;
                    end else begin
                        read = 1'b1;
                    end
                end
                COMMIT: clk_enable = 1'b1;
                default: ;
            endcase
        end
    end

    // Latch fetched word, access kind and load data; aborts read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (done) instr_q <= expire ? 32'h0 : readdata;
                end
                DECODE: wr_q <= data_write;
                DATA: begin
                    if (done && !wr_q) data_q <= expire ? 32'h0 : readdata;
                end
                default: ;
            endcase
        end
    end

endmodule
